// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared UART definitions: frame state encoding and parity modes.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        PAR   = 3'd4,
        STOP  = 3'd5
    } uart_state_t;

    localparam int PAR_NONE  = 0;
    localparam int PAR_EVEN  = 1;
    localparam int PAR_ODD   = 2;

    localparam int BIT_CNT_W = 4;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx                                                              |
// | Valid/ready UART transmitter; one line bit per baud tick, LSB first. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLKIN,
    input  logic                 RESETN,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx
);

    localparam logic [BIT_CNT_W-1:0] c_LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic                 c_LAST_STOP = 1'(STOP_BITS - 1);
    localparam bit                   c_HAS_PAR   = (PARITY != PAR_NONE);

    uart_state_t            r_state;
    uart_state_t            w_state_nxt;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [DATA_BITS-1:0]   w_shreg_nxt;
    logic                   r_parity;
    logic                   w_parity_nxt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_nxt;
    logic                   r_stop_cnt;
    logic                   w_stop_cnt_nxt;
    logic                   r_tx;
    logic                   w_tx_nxt;
    logic                   w_par_bit;

    assign w_par_bit = (PARITY == PAR_ODD) ? ~(^data) : (^data);

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_parity   <= w_parity_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // A tick in the transfer cycle is deliberately lost: IDLE never looks at baud.
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_parity_nxt   = r_parity;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_nxt       = r_tx;

        unique case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (valid) begin
                    w_shreg_nxt  = data;
                    w_parity_nxt = w_par_bit;
                    w_state_nxt  = ARMED;
                end
            end
            ARMED: begin
                if (baud) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (baud) begin
                    w_tx_nxt      = r_shreg[0];
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = DATA;
                end
            end
            DATA: begin
                if (baud) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        if (c_HAS_PAR) begin
                            w_tx_nxt    = r_parity;
                            w_state_nxt = PAR;
                        end else begin
                            w_tx_nxt       = 1'b1;
                            w_stop_cnt_nxt = 1'b0;
                            w_state_nxt    = STOP;
                        end
                    end else begin
                        w_shreg_nxt   = r_shreg >> 1;
                        w_tx_nxt      = r_shreg[1];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
            end
            PAR: begin
                if (baud) begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = STOP;
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (baud) begin
                    if (r_stop_cnt == c_LAST_STOP) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ready = (r_state == IDLE);
    assign busy  = ~ready;
    assign tx    = r_tx;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx                                                           |
// | Four transmitter configurations against a frame-bit scoreboard.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx;

    logic       CLKIN = 1'b0;
    logic       RESETN;
    logic       baud;
    logic [7:0] data_v [4];
    logic [3:0] valid_v;
    wire  [3:0] tx_v;
    wire  [3:0] ready_v;
    wire  [3:0] busy_v;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    // Instance order: 0 default, 1 even parity, 2 odd parity, 3 two stop bits
    int flen [4] = '{10, 11, 11, 11};

    always #5 CLKIN = ~CLKIN;
    always @(posedge CLKIN) cyc <= cyc + 1;
    assign baud = (cyc[1:0] == 2'd3);

    uart_tx u_dut (
        .CLKIN(CLKIN), .RESETN(RESETN), .baud(baud), .data(data_v[0]),
        .valid(valid_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .tx(tx_v[0])
    );
    uart_tx #(.PARITY(1)) u_even (
        .CLKIN(CLKIN), .RESETN(RESETN), .baud(baud), .data(data_v[1]),
        .valid(valid_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .tx(tx_v[1])
    );
    uart_tx #(.PARITY(2)) u_odd (
        .CLKIN(CLKIN), .RESETN(RESETN), .baud(baud), .data(data_v[2]),
        .valid(valid_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .tx(tx_v[2])
    );
    uart_tx #(.STOP_BITS(2)) u_stop2 (
        .CLKIN(CLKIN), .RESETN(RESETN), .baud(baud), .data(data_v[3]),
        .valid(valid_v[3]), .ready(ready_v[3]), .busy(busy_v[3]), .tx(tx_v[3])
    );

    logic q0 [$];
    logic q1 [$];
    logic q2 [$];
    logic q3 [$];

    function automatic void push_bit(input int k, input logic b);
        case (k)
            0: q0.push_back(b);
            1: q1.push_back(b);
            2: q2.push_back(b);
            default: q3.push_back(b);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic pop_bit(input int k);
        if (qsize(k) == 0) return 1'bx;
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    function automatic void qclear(input int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            2: q2.delete();
            default: q3.delete();
        endcase
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line monitor: detects the start edge, samples each bit on its closing tick.
    bit   in_frame  [4];
    bit   chk_rdy   [4];
    logic prev_tx   [4];
    int   bit_idx   [4];
    int   bit_start [4];
    int   last_fall [4];
    int   done_cnt  [4];
    logic prev_baud;

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_frame[k] = 1'b0; chk_rdy[k] = 1'b0; prev_tx[k] = 1'b1;
            bit_idx[k] = 0; bit_start[k] = 0; last_fall[k] = 0; done_cnt[k] = 0;
        end
        prev_baud = 1'b0;
        forever begin
            @(negedge CLKIN);
            for (int k = 0; k < 4; k++) begin
                if (!RESETN) begin
                    in_frame[k] = 1'b0;
                    chk_rdy[k]  = 1'b0;
                    qclear(k);
                end else begin
                    if (chk_rdy[k]) begin
                        chk_bit($sformatf("ready_rise_inst%0d", k), ready_v[k], 1'b1);
                        chk_bit($sformatf("busy_fall_inst%0d", k), busy_v[k], 1'b0);
                        chk_rdy[k] = 1'b0;
                        done_cnt[k]++;
                    end
                    if (!in_frame[k] && prev_tx[k] && !tx_v[k]) begin
                        in_frame[k]  = 1'b1;
                        bit_idx[k]   = 0;
                        bit_start[k] = cyc;
                        last_fall[k] = cyc;
                        chk_bit($sformatf("start_after_tick_inst%0d", k), prev_baud, 1'b1);
                    end
                    if (in_frame[k] && baud) begin
                        chk_int($sformatf("bit_width_inst%0d_bit%0d", k, bit_idx[k]),
                                cyc - bit_start[k], 3);
                        chk_bit($sformatf("tx_inst%0d_bit%0d", k, bit_idx[k]),
                                tx_v[k], pop_bit(k));
                        bit_idx[k]++;
                        bit_start[k] = cyc + 1;
                        if (bit_idx[k] == flen[k]) begin
                            chk_bit($sformatf("ready_not_early_inst%0d", k), ready_v[k], 1'b0);
                            in_frame[k] = 1'b0;
                            chk_rdy[k]  = 1'b1;
                        end
                    end
                end
                prev_tx[k] = tx_v[k];
            end
            prev_baud = baud;
        end
    end

    task automatic send(input int k, input logic [7:0] d, input logic [11:0] fr,
                        input bit align, output int xc);
        int n;
        n = 0;
        @(negedge CLKIN);
        while (!(ready_v[k] && (!align || cyc[1:0] == 2'd3)) && n < 100) begin
            @(negedge CLKIN);
            n++;
        end
        chk_bit($sformatf("send_wait_inst%0d", k), n < 100, 1'b1);
        data_v[k]  = d;
        valid_v[k] = 1'b1;
        xc = cyc;
        for (int i = 0; i < flen[k]; i++) push_bit(k, fr[i]);
        @(negedge CLKIN);
        valid_v[k] = 1'b0;
        chk_bit($sformatf("ready_drop_inst%0d", k), ready_v[k], 1'b0);
        chk_bit($sformatf("busy_rise_inst%0d", k), busy_v[k], 1'b1);
    endtask

    task automatic wait_done(input int k, input int target, input int xc, input int exact);
        int n;
        int dly;
        n = 0;
        while (done_cnt[k] < target && n < 400) begin
            @(negedge CLKIN);
            #1;
            n++;
        end
        chk_bit($sformatf("frame_done_inst%0d", k), done_cnt[k] >= target, 1'b1);
        chk_int($sformatf("queue_empty_inst%0d", k), qsize(k), 0);
        dly = last_fall[k] - xc;
        if (exact >= 0) chk_int($sformatf("start_delay_inst%0d", k), dly, exact);
        else chk_bit($sformatf("start_delay_range_inst%0d", k), (dly >= 2) && (dly <= 5), 1'b1);
    endtask

    typedef struct {
        int          inst;
        logic [7:0]  d;
        logic [11:0] frame;   // bit i is the i-th bit on the line
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          xc;
        int          xc2;
        int          rise;
        int          base;
        int          n;
        logic [11:0] fr;

        vecs[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}};
        vecs[1] = '{1, 8'hA5, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}};
        vecs[2] = '{2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
        vecs[3] = '{2, 8'h00, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}};
        vecs[4] = '{1, 8'h01, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}};
        vecs[5] = '{0, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}};
        vecs[6] = '{3, 8'h5A, {1'b0, 2'b11, 8'h5A, 1'b0}};

        RESETN  = 1'b0;
        valid_v = 4'h0;
        for (int k = 0; k < 4; k++) data_v[k] = 8'h00;
        repeat (3) @(negedge CLKIN);
        chk_int("reset_tx", int'(tx_v), 15);
        chk_int("reset_ready", int'(ready_v), 15);
        chk_int("reset_busy", int'(busy_v), 0);
        RESETN = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge CLKIN);
            chk_int("idle_lines", int'({tx_v, ready_v, busy_v}), 12'hFF0);
        end

        for (int i = 0; i < 7; i++) begin
            base = done_cnt[vecs[i].inst];
            send(vecs[i].inst, vecs[i].d, vecs[i].frame, 1'b0, xc);
            wait_done(vecs[i].inst, base + 1, xc, -1);
        end

        // Transfer coincides with a tick: start bit must wait for the next one
        base = done_cnt[0];
        send(0, 8'hC3, {2'b00, 1'b1, 8'hC3, 1'b0}, 1'b1, xc);
        wait_done(0, base + 1, xc, 5);

        // Two stop bits, valid held across two frames; data changes mid-frame
        base = done_cnt[3];
        n = 0;
        @(negedge CLKIN);
        while (!ready_v[3] && n < 100) begin @(negedge CLKIN); n++; end
        fr = {1'b0, 2'b11, 8'h00, 1'b0};
        for (int i = 0; i < 11; i++) push_bit(3, fr[i]);
        data_v[3]  = 8'h00;
        valid_v[3] = 1'b1;
        @(negedge CLKIN);
        chk_bit("b2b_first_accept", ready_v[3], 1'b0);
        data_v[3] = 8'hFF;
        fr = {1'b0, 2'b11, 8'hFF, 1'b0};
        for (int i = 0; i < 11; i++) push_bit(3, fr[i]);
        n = 0;
        while (!ready_v[3] && n < 200) begin @(negedge CLKIN); n++; end
        chk_bit("b2b_ready_returns", n < 200, 1'b1);
        rise = cyc;
        xc2  = cyc;
        @(negedge CLKIN);
        valid_v[3] = 1'b0;
        chk_bit("b2b_second_accept", ready_v[3], 1'b0);
        wait_done(3, base + 2, xc2, -1);
        chk_bit("b2b_gap_after_ready", (last_fall[3] - rise) >= 2, 1'b1);

        // Asynchronous reset in the middle of the data bits of 0x55
        send(0, 8'h55, {2'b00, 1'b1, 8'h55, 1'b0}, 1'b0, xc);
        n = 0;
        while (!(in_frame[0] && bit_idx[0] >= 2 && tx_v[0] == 1'b0) && n < 200) begin
            @(negedge CLKIN);
            #1;
            n++;
        end
        chk_bit("rst_reached_data_low", n < 200, 1'b1);
        @(posedge CLKIN);
        #1 RESETN = 1'b0;
        #1;
        chk_bit("rst_async_tx", tx_v[0], 1'b1);
        chk_bit("rst_async_ready", ready_v[0], 1'b1);
        chk_bit("rst_async_busy", busy_v[0], 1'b0);
        repeat (2) @(negedge CLKIN);
        RESETN = 1'b1;
        base = done_cnt[0];
        send(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 1'b0, xc);
        wait_done(0, base + 1, xc, -1);

        repeat (10) @(negedge CLKIN);
        chk_int("final_idle", int'({tx_v, ready_v, busy_v}), 12'hFF0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Byte-serialising UART transmitter that sits directly downstream of the baud tick generator. It accepts one data word at a time over a valid/ready handshake and shifts it out LSB-first as a start/data/parity/stop frame. The line advances one bit per baud tick. It owns the serial `tx` line driven to the pad.

## Interface

Parameters:
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `PARITY`, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: stop bits per frame, legal values 1 or 2.

Ports:
- `CLKIN` input, 1: sole clock; all state updates on its rising edge.
- `RESETN` input, 1: reset, asynchronous, active-low.
- `baud` input, 1: one-cycle-high bit-period tick from the baud generator.
- `data` input, `DATA_BITS`: word to send, sampled on handshake.
- `valid` input, 1: `data` is presented.
- `ready` output, 1: the block will accept `data` this cycle.
- `busy` output, 1: a frame is armed or in flight.
- `tx` output, 1: serial line, idle high.

## Operation

Handshake:
- Transfer occurs in any cycle with `valid && ready`.
- On transfer: `data` is latched into the shift register, and parity is computed and latched.

States:
- IDLE
  - `tx` = 1, `ready` = 1, `busy` = 0.
  - `baud` is ignored.
  - Transfer → ARMED.
- ARMED
  - `tx` = 1, `ready` = 0, `busy` = 1.
  - On `baud`: `tx` ← 0 → START.
- START
  - On `baud`: `tx` ← shreg[0], bit counter ← 0 → DATA.
- DATA
  - On `baud` with counter < `DATA_BITS`−1: shift right, `tx` ← next bit, counter +1.
  - On `baud` with counter = `DATA_BITS`−1:
    - If `PARITY` ≠ 0: `tx` ← parity bit → PAR.
    - Otherwise: `tx` ← 1, stop counter ← 0 → STOP.
- PAR
  - On `baud`: `tx` ← 1, stop counter ← 0 → STOP.
- STOP
  - On `baud` with stop counter < `STOP_BITS`−1: stop counter +1.
  - On `baud` with stop counter = `STOP_BITS`−1: → IDLE, `tx` stays 1.

Signal rules:
- Parity bit: even = XOR-reduce(data); odd = its inverse.
- `ready` = (state == IDLE), decoded from registered state.
- `busy` = !`ready`.
- `tx` is a register; never glitches.

Widths:
- Bit counter: 4 bits; stop counter: 1 bit.
- No wrap is possible: the counters reset on entry to their states.

Boundary conditions:
- Transfer and `baud` in the same IDLE cycle: the tick is ignored. The start bit begins at the first `baud` strictly after the transfer cycle.
- `valid` held through a frame: no second transfer until IDLE. Back-to-back frames are separated by at least one ARMED wait, i.e. up to one bit period of idle-high.
- `valid` deasserted while not ready: no effect.
- `baud` asserted on consecutive cycles: each assertion is a tick; no filtering.
- Reset mid-frame: state → IDLE, `tx` → 1 immediately (async). The partial frame is abandoned.

Reset values:
- `tx` = 1, `ready` = 1, `busy` = 0.
- State = IDLE; shift register, parity and counters = 0.

## Timing

- Transfer cycle T: `ready` low from T+1.
- The start bit appears on `tx` the cycle after the first `baud` at or after T+1.
- Each bit is held from the cycle after one tick to the cycle of the next tick.
- Frame length is (1 + `DATA_BITS` + (`PARITY` ≠ 0) + `STOP_BITS`) tick intervals.
- `ready` returns high the cycle after the final stop-bit tick.
- Default config at the system tick period (one tick per 415 `CLKIN` cycles): a frame lasts 10 × 415 cycles.

## Structure

- Shared package `uart_pkg`:
  - State enum (IDLE, ARMED, START, DATA, PAR, STOP).
  - Parity mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
- The package is reused by the future `uart_rx`.
- Single module, no sub-module. Parity is an inline XOR reduce.

## Test plan

All scenarios use a bench `baud` pulse every 4 cycles.

- Reset, then idle 50 cycles → `tx` = 1, `ready` = 1, `busy` = 0 throughout; `baud` has no effect.
- Default params, send 0xA5 → `tx` bit sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 4 cycles; `ready` high again 1 cycle after the 10th tick.
- `PARITY`=1, send 0xA5 → parity bit 0. `PARITY`=2, send 0x07 → parity bit 0. `PARITY`=2, send 0x00 → parity bit 1. All with 11-bit frames.
- `STOP_BITS`=2, `valid` held continuously with 0x00 then 0xFF → two frames, each ending in two high bits. The second start edge comes no earlier than the first tick after `ready` re-rises.
- Transfer in the same cycle as `baud` → `tx` stays high until the next tick (4 cycles later), then start bit.
- Assert `RESETN` low during the DATA state of 0x55 → `tx` = 1 and `ready` = 1 asynchronously. After release, a new send of 0x3C produces a clean frame.
